// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared definitions for param_proc_core. Holds the opcode
//                encodings, the controller state encoding, the status-flag
//                bit positions and a small opcode-legality helper.
//  Revision    : 1.0  initial release
// ============================================================================
package proc_pkg;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_MOVE = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_XOR  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_DIV  = 4'd7,
    OP_MOD  = 4'd8
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_A  = 3'd1,
    S_EXEC     = 3'd2,
    S_DIV_ITER = 3'd3,
    S_WRITE    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Bit positions inside the internal status-flag vector
  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_DZ   = 2;
  localparam int FLAG_ILL  = 3;
  localparam int NUM_FLAGS = 4;

  // Every encoding above OP_MOD is unassigned
  function automatic logic is_illegal(input logic [3:0] f);
    return (f > OP_MOD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Unsigned restoring divider, one quotient bit per clock.
//                A start with a non-zero divisor loads the operands; WIDTH
//                steps follow, then done pulses for one cycle with quotient
//                and remainder valid (they hold until the next start).
//  Ports       : clk, rst            clock, async active-high reset
//                start               load operands (ignored if divisor == 0)
//                dividend, divisor   operands
//                busy                iteration in progress
//                done                one-cycle completion pulse
//                quotient, remainder results
//                div_zero            divisor input is currently zero
//  Revision    : 1.0  initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   w_trial;

  assign div_zero = (divisor == '0);

  // Partial remainder shifted left by one with the next dividend bit brought
  // in (held in the quotient MSB), minus the divisor. MSB set means negative:
  // restore, i.e. keep the shifted value and record a 0 quotient bit.
  assign w_trial = {remainder, quotient[WIDTH-1]} - {1'b0, r_div};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (start && !div_zero) begin
        remainder <= '0;
        quotient  <= dividend;
        r_div     <= divisor;
        r_cnt     <= CNT_W'(WIDTH);
        busy      <= 1'b1;
      end else if (busy) begin
        if (!w_trial[WIDTH]) begin
          remainder <= w_trial[WIDTH-1:0];
          quotient  <= {quotient[WIDTH-2:0], 1'b1};
        end else begin
          remainder <= {remainder[WIDTH-2:0], quotient[WIDTH-1]};
          quotient  <= {quotient[WIDTH-2:0], 1'b0};
        end
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/param_proc_core.sv
`default_nettype none
// ============================================================================
//  Module      : param_proc_core
//  Description : WIDTH-bit multi-cycle processor core. Register file of
//                NUM_REGS entries, A/G staging registers, ALU, iterative
//                divider, status flags and a combinational debug read port.
//                One instruction in flight at a time, start/done handshake.
//  Ports       : clk, rst          clock, async active-high reset
//                start             instruction request (taken when busy=0)
//                func, rx, ry      opcode, dest/first operand, second operand
//                data_in           LOAD immediate
//                busy, done        in-flight indicator, completion pulse
//                result            value written to Rx (0 if no write)
//                flag_c/z/dz/ill   carry/borrow, zero, div-by-zero, illegal
//                dbg_sel, dbg_data debug register read
//  Revision    : 1.0  initial release
// ============================================================================
module param_proc_core
  import proc_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NUM_REGS = 8,
  localparam int RSEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        func,
  input  logic [RSEL_W-1:0] rx,
  input  logic [RSEL_W-1:0] ry,
  input  logic [WIDTH-1:0]  data_in,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_dz,
  output logic              flag_ill,
  input  logic [RSEL_W-1:0] dbg_sel,
  output logic [WIDTH-1:0]  dbg_data
);

  state_t               r_state;
  logic [3:0]           r_func;
  logic [RSEL_W-1:0]    r_rx;
  logic [RSEL_W-1:0]    r_ry;
  logic [WIDTH-1:0]     r_imm;
  logic [WIDTH-1:0]     r_regs [NUM_REGS];
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_g;
  logic                 r_c;    // carry/borrow captured alongside G
  logic                 r_dz;   // divide-by-zero captured alongside G
  logic [NUM_FLAGS-1:0] r_flags;

  logic [WIDTH-1:0] w_rx_val;
  logic [WIDTH-1:0] w_ry_val;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu;
  logic             w_alu_c;
  logic             w_accept;
  logic             w_is_div;
  logic             w_div_start;
  logic             w_div_busy;
  logic             w_div_done;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  // Completion of the current instruction on this edge
  logic             w_fin;
  logic             w_wr;
  logic [WIDTH-1:0] w_val;
  logic             w_fc;
  logic             w_fdz;
  logic             w_fill;

  assign w_rx_val = r_regs[r_rx];
  assign w_ry_val = r_regs[r_ry];
  assign dbg_data = r_regs[dbg_sel];

  assign flag_c   = r_flags[FLAG_C];
  assign flag_z   = r_flags[FLAG_Z];
  assign flag_dz  = r_flags[FLAG_DZ];
  assign flag_ill = r_flags[FLAG_ILL];

  // The done cycle already has busy=0, so an instruction may be taken there
  assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_is_div    = (r_func == OP_DIV) || (r_func == OP_MOD);
  assign w_div_start = (r_state == S_FETCH_A) && w_is_div;

  assign w_sum  = {1'b0, r_a} + {1'b0, w_ry_val};
  assign w_diff = {1'b0, r_a} - {1'b0, w_ry_val};

  always_comb begin
    w_alu   = '0;
    w_alu_c = 1'b0;
    case (r_func)
      OP_ADD: begin w_alu = w_sum[WIDTH-1:0];  w_alu_c = w_sum[WIDTH];  end
      OP_SUB: begin w_alu = w_diff[WIDTH-1:0]; w_alu_c = w_diff[WIDTH]; end
      OP_XOR: w_alu = r_a ^ w_ry_val;
      OP_AND: w_alu = r_a & w_ry_val;
      OP_OR:  w_alu = r_a | w_ry_val;
      default: ;
    endcase
  end

  always_comb begin
    w_fin  = 1'b0;
    w_wr   = 1'b0;
    w_val  = '0;
    w_fc   = 1'b0;
    w_fdz  = 1'b0;
    w_fill = 1'b0;
    case (r_state)
      S_FETCH_A: begin
        if (r_func == OP_LOAD) begin
          w_fin = 1'b1; w_wr = 1'b1; w_val = r_imm;
        end else if (r_func == OP_MOVE) begin
          w_fin = 1'b1; w_wr = 1'b1; w_val = w_ry_val;
        end else if (is_illegal(r_func)) begin
          w_fin = 1'b1; w_fill = 1'b1;
        end
      end
      S_WRITE: begin
        w_fin = 1'b1; w_wr = 1'b1; w_val = r_g; w_fc = r_c; w_fdz = r_dz;
      end
      S_DIV_ITER: begin
        if (w_div_done) begin
          w_fin = 1'b1;
          w_wr  = 1'b1;
          w_val = (r_func == OP_DIV) ? w_quo : w_rem;
        end
      end
      default: ;
    endcase
  end

  seq_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .dividend  (w_rx_val),
    .divisor   (w_ry_val),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem),
    .div_zero  (w_div_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_func  <= '0;
      r_rx    <= '0;
      r_ry    <= '0;
      r_imm   <= '0;
      r_a     <= '0;
      r_g     <= '0;
      r_c     <= 1'b0;
      r_dz    <= 1'b0;
      r_flags <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      done <= w_fin;
      if (w_fin) begin
        result            <= w_val;
        r_flags[FLAG_C]   <= w_fc;
        r_flags[FLAG_Z]   <= (w_val == '0);
        r_flags[FLAG_DZ]  <= w_fdz;
        r_flags[FLAG_ILL] <= w_fill;
      end
      if (w_wr) r_regs[r_rx] <= w_val;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_func  <= func;
            r_rx    <= rx;
            r_ry    <= ry;
            r_imm   <= data_in;
            busy    <= 1'b1;
            r_state <= S_FETCH_A;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_FETCH_A: begin
          r_a <= w_rx_val;
          if (w_fin) begin
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else if (w_is_div) begin
            if (w_div_zero) begin
              // Zero divisor: skip iteration; DIV saturates, MOD keeps Rx
              r_g     <= (r_func == OP_DIV) ? '1 : w_rx_val;
              r_c     <= 1'b0;
              r_dz    <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_state <= S_DIV_ITER;
            end
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_g     <= w_alu;
          r_c     <= w_alu_c;
          r_dz    <= 1'b0;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          busy    <= 1'b0;
          r_state <= S_DONE;
        end
        S_DIV_ITER: begin
          if (w_div_done) begin
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else if (!w_div_busy) begin
            // Divider idle without a result: recover rather than hang
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
